// File: rtl/stack_pkg.sv
// stack_pkg: op encodings, FSM states, default stack bounds and per-op word counts.
package stack_pkg;
   typedef enum logic [2:0] {
      OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_INT, OP_RTI, OP_RSV6, OP_RSV7
   } op_e;
   typedef enum logic [2:0] {IDLE, PUSH_W, POP_A, POP_D, RESP} state_e;
   localparam logic [7:0] DEF_STACK_TOP   = 8'hFF;
   localparam logic [7:0] DEF_STACK_LIMIT = 8'h80;
   function automatic logic is_push(op_e op);
      return op == OP_PUSH || op == OP_CALL || op == OP_INT;
   endfunction
   function automatic logic is_pop(op_e op);
      return op == OP_POP || op == OP_RET || op == OP_RTI;
   endfunction
   function automatic logic [1:0] op_words(op_e op);
      return (op == OP_INT || op == OP_RTI) ? 2'd2 : (is_push(op) || is_pop(op)) ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: request/response, SP-update and data-memory signals of the stack controller.
interface stack_ctrl_if;
   logic       req_valid, req_ready;
   logic [2:0] req_op;
   logic [7:0] req_data;
   logic [3:0] req_flags;
   logic [7:0] sp_value, sp_new;
   logic       sp_update_enable;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flags;
   logic       stack_empty, stack_full, fault;
   modport master (
      output req_valid, req_op, req_data, req_flags, sp_value, mem_rdata,
      input  req_ready, sp_update_enable, sp_new, mem_en, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_data, rsp_flags, stack_empty, stack_full, fault
   );
   modport slave (
      input  req_valid, req_op, req_data, req_flags, sp_value, mem_rdata,
      output req_ready, sp_update_enable, sp_new, mem_en, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_data, rsp_flags, stack_empty, stack_full, fault
   );
endinterface

// File: rtl/stack_bounds_check.sv
// stack_bounds_check: flags over/underflow of a request against the current SP; reserved ops always fault.
module stack_bounds_check
   import stack_pkg::*;
#(
   parameter logic [7:0] TOP   = DEF_STACK_TOP,
   parameter logic [7:0] LIMIT = DEF_STACK_LIMIT
) (
   input  logic [2:0] op_i,
   input  logic [7:0] sp_i,
   output logic       fault_o
);
   op_e        op;
   logic [8:0] n, dn, up;
   assign op = op_e'(op_i);
   assign n  = {7'd0, op_words(op)};
   assign dn = {1'b0, sp_i} - n;
   assign up = {1'b0, sp_i} + n;
   always_comb fault_o = is_push(op) ? (dn < ({1'b0, LIMIT} - 9'd1)) :
                         is_pop(op)  ? (up > {1'b0, TOP}) : 1'b1;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences stack memory accesses and SP updates for PUSH/POP/CALL/RET/INT/RTI.
// Define STACK_GUARD_EN to reject over/underflowing requests with fault instead of wrapping.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter logic [7:0] STACK_TOP   = DEF_STACK_TOP,
   parameter logic [7:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
   input logic         clk,
   input logic         reset,
   stack_ctrl_if.slave bus
);
   state_e     state_q;
   logic [1:0] cnt_q;
   logic [7:0] sp_work_q, mem_addr_q, mem_wdata_q, sp_new_q, rsp_data_q;
   logic [3:0] flags_q, rsp_flags_q;
   logic       rdy_q, mem_en_q, mem_we_q, upd_q, rsp_valid_q, fault_q, flt;
   op_e        op;
   assign op = op_e'(bus.req_op);
`ifdef STACK_GUARD_EN
   stack_bounds_check #(.TOP(STACK_TOP), .LIMIT(STACK_LIMIT)) u_bounds (
      .op_i(bus.req_op), .sp_i(bus.sp_value), .fault_o(flt)
   );
`else
   assign flt = 1'b0;
`endif
   assign bus.req_ready        = rdy_q;
   assign bus.mem_en           = mem_en_q;
   assign bus.mem_we           = mem_we_q;
   assign bus.mem_addr         = mem_addr_q;
   assign bus.mem_wdata        = mem_wdata_q;
   assign bus.sp_update_enable = upd_q;
   assign bus.sp_new           = sp_new_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_data         = rsp_data_q;
   assign bus.rsp_flags        = rsp_flags_q;
   assign bus.fault            = fault_q;
   assign bus.stack_empty      = bus.sp_value == STACK_TOP;
   assign bus.stack_full       = bus.sp_value == STACK_LIMIT - 8'd1;
   // Outputs are registered, so each transition issues the strobes of the cycle it enters;
   // sp_work_q always holds the SP value after the most recently issued update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b1;
         cnt_q       <= 2'd0;
         sp_work_q   <= STACK_TOP;
         flags_q     <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         upd_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         mem_addr_q  <= 8'd0;
         mem_wdata_q <= 8'd0;
         sp_new_q    <= 8'd0;
         rsp_data_q  <= 8'd0;
         rsp_flags_q <= 4'd0;
      end else begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         upd_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         fault_q     <= 1'b0;
         rdy_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               rdy_q <= !bus.req_valid;
               if (bus.req_valid) begin
                  flags_q     <= bus.req_flags;
                  cnt_q       <= op_words(op);
                  sp_work_q   <= bus.sp_value;
                  rsp_data_q  <= 8'd0;
                  rsp_flags_q <= 4'd0;
                  if (flt || !(is_push(op) || is_pop(op))) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     fault_q     <= flt;
                  end else if (is_push(op)) begin
                     state_q     <= PUSH_W;
                     mem_en_q    <= 1'b1;
                     mem_we_q    <= 1'b1;
                     upd_q       <= 1'b1;
                     mem_addr_q  <= bus.sp_value;
                     mem_wdata_q <= bus.req_data;
                     sp_new_q    <= bus.sp_value - 8'd1;
                     sp_work_q   <= bus.sp_value - 8'd1;
                  end else begin
                     state_q    <= POP_A;
                     mem_en_q   <= 1'b1;
                     upd_q      <= 1'b1;
                     mem_addr_q <= bus.sp_value + 8'd1;
                     sp_new_q   <= bus.sp_value + 8'd1;
                     sp_work_q  <= bus.sp_value + 8'd1;
                  end
               end
            end
            PUSH_W: begin
               if (cnt_q == 2'd2) begin
                  cnt_q       <= 2'd1;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b1;
                  upd_q       <= 1'b1;
                  mem_addr_q  <= sp_work_q;
                  mem_wdata_q <= {4'h0, flags_q};
                  sp_new_q    <= sp_work_q - 8'd1;
                  sp_work_q   <= sp_work_q - 8'd1;
               end else begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            POP_A: state_q <= POP_D;
            POP_D: begin
               if (cnt_q == 2'd2) begin
                  cnt_q       <= 2'd1;
                  rsp_flags_q <= bus.mem_rdata[3:0];
                  state_q     <= POP_A;
                  mem_en_q    <= 1'b1;
                  upd_q       <= 1'b1;
                  mem_addr_q  <= sp_work_q + 8'd1;
                  sp_new_q    <= sp_work_q + 8'd1;
                  sp_work_q   <= sp_work_q + 8'd1;
               end else begin
                  rsp_data_q  <= bus.mem_rdata;
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed checks of stack_ctrl with a modelled SP register and data memory.
module tb_stack_ctrl;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   stack_ctrl_if bus();
   stack_ctrl dut(.clk(clk), .reset(reset), .bus(bus));
   logic [7:0] mem [256];
   always_ff @(posedge clk) begin
      if (reset) bus.sp_value <= 8'hFF;
      else if (bus.sp_update_enable) bus.sp_value <= bus.sp_new;
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
   end
   int tests = 0, fails = 0;
   int lat, n_acc, n_upd;
   logic [7:0] r_data;
   logic [3:0] r_flags;
   logic       r_fault;
   int         a_cyc [4];
   logic       a_we [4];
   logic [7:0] a_addr [4], a_wdata [4], a_spnew [4];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Issue one request and record every strobe until the response (bounded).
   task automatic run(input logic [2:0] op, input logic [7:0] d, input logic [3:0] f);
      n_acc = 0; n_upd = 0; lat = 0;
      r_data = 8'h00; r_flags = 4'h0; r_fault = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d; bus.req_flags = f;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (bus.sp_update_enable) n_upd++;
         if (bus.mem_en && n_acc < 4) begin
            a_cyc[n_acc] = k; a_we[n_acc] = bus.mem_we; a_addr[n_acc] = bus.mem_addr;
            a_wdata[n_acc] = bus.mem_wdata; a_spnew[n_acc] = bus.sp_new;
            n_acc++;
         end
         if (bus.rsp_valid) begin
            lat = k; r_data = bus.rsp_data; r_flags = bus.rsp_flags; r_fault = bus.fault;
         end
      end
      chk("rsp_seen", lat != 0, 1);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_data = 8'd0; bus.req_flags = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_sp_upd", bus.sp_update_enable, 0);
      chk("rst_sp_new", bus.sp_new, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_empty", bus.stack_empty, 1);
      reset = 1'b0;
      run(3'd0, 8'h5A, 4'h0);
      chk("push_lat", lat, 2);
      chk("push_nacc", n_acc, 1);
      chk("push_cyc", a_cyc[0], 1);
      chk("push_we", a_we[0], 1);
      chk("push_addr", a_addr[0], 8'hFF);
      chk("push_wdata", a_wdata[0], 8'h5A);
      chk("push_spnew", a_spnew[0], 8'hFE);
      chk("push_rdata", r_data, 0);
      chk("push_empty", bus.stack_empty, 0);
      chk("push_sp", bus.sp_value, 8'hFE);
      run(3'd1, 8'h00, 4'h0);
      chk("pop_lat", lat, 3);
      chk("pop_we", a_we[0], 0);
      chk("pop_addr", a_addr[0], 8'hFF);
      chk("pop_spnew", a_spnew[0], 8'hFF);
      chk("pop_data", r_data, 8'h5A);
      chk("pop_sp", bus.sp_value, 8'hFF);
      chk("pop_empty", bus.stack_empty, 1);
      run(3'd2, 8'h11, 4'h0);
      chk("call_lat", lat, 2);
      run(3'd3, 8'h00, 4'h0);
      chk("ret_lat", lat, 3);
      chk("ret_data", r_data, 8'h11);
      chk("ret_flags", r_flags, 0);
      run(3'd4, 8'h42, 4'hA);
      chk("int_lat", lat, 3);
      chk("int_nacc", n_acc, 2);
      chk("int_cyc1", a_cyc[1], 2);
      chk("int_addr0", a_addr[0], 8'hFF);
      chk("int_wdata0", a_wdata[0], 8'h42);
      chk("int_addr1", a_addr[1], 8'hFE);
      chk("int_wdata1", a_wdata[1], 8'h0A);
      chk("int_spnew1", a_spnew[1], 8'hFD);
      chk("int_sp", bus.sp_value, 8'hFD);
      run(3'd5, 8'h00, 4'h0);
      chk("rti_lat", lat, 5);
      chk("rti_nacc", n_acc, 2);
      chk("rti_nupd", n_upd, 2);
      chk("rti_cyc1", a_cyc[1], 3);
      chk("rti_addr0", a_addr[0], 8'hFE);
      chk("rti_addr1", a_addr[1], 8'hFF);
      chk("rti_flags", r_flags, 4'hA);
      chk("rti_data", r_data, 8'h42);
      chk("rti_sp", bus.sp_value, 8'hFF);
      run(3'd6, 8'h99, 4'h3);
      chk("rsv_lat", lat, 1);
      chk("rsv_nacc", n_acc, 0);
      chk("rsv_nupd", n_upd, 0);
`ifdef STACK_GUARD_EN
      chk("rsv_fault", r_fault, 1);
      run(3'd1, 8'h00, 4'h0);
      chk("under_lat", lat, 1);
      chk("under_fault", r_fault, 1);
      chk("under_nacc", n_acc, 0);
      chk("under_nupd", n_upd, 0);
      chk("under_sp", bus.sp_value, 8'hFF);
`else
      chk("rsv_fault", r_fault, 0);
      run(3'd1, 8'h00, 4'h0);
      chk("wrap_lat", lat, 3);
      chk("wrap_addr", a_addr[0], 8'h00);
      chk("wrap_sp", bus.sp_value, 8'h00);
      chk("wrap_fault", r_fault, 0);
      run(3'd0, 8'h77, 4'h0);
      chk("wrap_push_addr", a_addr[0], 8'h00);
      chk("wrap_push_sp", bus.sp_value, 8'hFF);
`endif
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_data = 8'h33; bus.req_flags = 4'h5;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid_w1", bus.mem_en, 1);
      @(negedge clk);
      chk("mid_w2_addr", bus.mem_addr, 8'hFE);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_mem_en", bus.mem_en, 0);
      chk("mid_sp_upd", bus.sp_update_enable, 0);
      chk("mid_ready", bus.req_ready, 1);
      chk("mid_rsp", bus.rsp_valid, 0);
      chk("mid_sp", bus.sp_value, 8'hFF);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_idle_mem_en", bus.mem_en, 0);
      for (int i = 0; i < 128; i++) run(3'd0, 8'hC0, 4'h0);
      chk("full_sp", bus.sp_value, 8'h7F);
      chk("full_flag", bus.stack_full, 1);
      run(3'd0, 8'hEE, 4'h0);
`ifdef STACK_GUARD_EN
      chk("over_lat", lat, 1);
      chk("over_fault", r_fault, 1);
      chk("over_nacc", n_acc, 0);
      chk("over_sp", bus.sp_value, 8'h7F);
`else
      chk("over_lat", lat, 2);
      chk("over_addr", a_addr[0], 8'h7F);
      chk("over_sp", bus.sp_value, 8'h7E);
      chk("over_full", bus.stack_full, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
